// File: rtl/multicycle_main_control_pkg.sv
// rtl/multicycle_main_control_pkg.sv - opcodes, ALUOp codes, mux selects and state encodings
package multicycle_main_control_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // Shared with the downstream ALU-control decoder.
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTEX   = 4'd6,
        S_RTWB   = 4'd7,
        S_BEQEX  = 4'd8,
        S_JEX    = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_TRAP   = 4'd15
    } state_t;

endpackage

// File: rtl/multicycle_main_control_if.sv
// rtl/multicycle_main_control_if.sv - control <-> datapath/memory signal bundle
interface multicycle_main_control_if #(parameter int OPW = 6);
    logic [OPW-1:0] opcode;
    logic           zero;
    logic           mem_ready;
    logic [1:0]     alu_op;
    logic           alu_src_a;
    logic [1:0]     alu_src_b;
    logic [1:0]     pc_src;
    logic           pc_en;
    logic           ior_d;
    logic           mem_rd;
    logic           mem_wr;
    logic           ir_write;
    logic           reg_write;
    logic           reg_dst;
    logic           mem_to_reg;
    logic           illegal;
    logic [3:0]     state_dbg;

    modport master (
        input  opcode, zero, mem_ready,
        output alu_op, alu_src_a, alu_src_b, pc_src, pc_en, ior_d, mem_rd, mem_wr,
               ir_write, reg_write, reg_dst, mem_to_reg, illegal, state_dbg
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  alu_op, alu_src_a, alu_src_b, pc_src, pc_en, ior_d, mem_rd, mem_wr,
               ir_write, reg_write, reg_dst, mem_to_reg, illegal, state_dbg
    );
endinterface

// File: rtl/mc_opcode_decode.sv
// rtl/mc_opcode_decode.sv - opcode to post-DECODE state lookup; MC_ADDI_EN enables addi
module mc_opcode_decode
    import multicycle_main_control_pkg::*;
#(
    parameter int OPW = 6
) (
    input  logic [OPW-1:0] opcode,
    output state_t         next_state,
    output logic           illegal
);
    always_comb begin
        next_state = S_TRAP;
        illegal    = 1'b1;
        case (opcode)
            OPW'(OP_RTYPE): begin next_state = S_RTEX;   illegal = 1'b0; end
            OPW'(OP_LW),
            OPW'(OP_SW):    begin next_state = S_MEMADR; illegal = 1'b0; end
            OPW'(OP_BEQ):   begin next_state = S_BEQEX;  illegal = 1'b0; end
            OPW'(OP_J):     begin next_state = S_JEX;    illegal = 1'b0; end
`ifdef MC_ADDI_EN
            OPW'(OP_ADDI):  begin next_state = S_ADDIEX; illegal = 1'b0; end
`endif
            default: ;
        endcase
    end
endmodule

// File: rtl/multicycle_main_control.sv
// rtl/multicycle_main_control.sv - multicycle MIPS main-control FSM; MC_ADDI_EN adds addi states
module multicycle_main_control
    import multicycle_main_control_pkg::*;
#(
    parameter int OPW          = 6,
    parameter bit ILLEGAL_HOLD = 1'b1
) (
    input logic                        clk,
    input logic                        reset,
    multicycle_main_control_if.master  bus
);
    state_t         state, next_state, dec_state;
    logic           dec_illegal;
    logic [OPW-1:0] op_q;
    logic           mem_go;

    // Memory handshake is ignored while reset is held so no PC/IR write can leak out.
    assign mem_go = bus.mem_ready & ~reset;

    mc_opcode_decode #(.OPW(OPW)) u_decode (
        .opcode     (bus.opcode),
        .next_state (dec_state),
        .illegal    (dec_illegal)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_FETCH;
            op_q  <= '0;
        end else begin
            state <= next_state;
            if (state == S_DECODE) op_q <= bus.opcode;
        end
    end

    always_comb begin
        next_state = S_FETCH;
        case (state)
            S_FETCH:  next_state = mem_go ? S_DECODE : S_FETCH;
            S_DECODE: next_state = dec_illegal ? S_TRAP : dec_state;
            S_MEMADR: next_state = (op_q == OPW'(OP_SW)) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  next_state = mem_go ? S_MEMWB : S_MEMRD;
            S_MEMWR:  next_state = mem_go ? S_FETCH : S_MEMWR;
            S_RTEX:   next_state = S_RTWB;
`ifdef MC_ADDI_EN
            S_ADDIEX: next_state = S_ADDIWB;
`endif
            S_TRAP:   next_state = ILLEGAL_HOLD ? S_TRAP : S_FETCH;
            default:  next_state = S_FETCH;
        endcase
    end

    always_comb begin
        bus.alu_op     = ALUOP_ADD;
        bus.alu_src_a  = 1'b0;
        bus.alu_src_b  = SRCB_REG;
        bus.pc_src     = PCSRC_ALU;
        bus.pc_en      = 1'b0;
        bus.ior_d      = 1'b0;
        bus.mem_rd     = 1'b0;
        bus.mem_wr     = 1'b0;
        bus.ir_write   = 1'b0;
        bus.reg_write  = 1'b0;
        bus.reg_dst    = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.illegal    = 1'b0;
        bus.state_dbg  = state;
        case (state)
            S_FETCH: begin
                bus.mem_rd    = 1'b1;
                bus.alu_src_b = SRCB_FOUR;
                bus.pc_en     = mem_go;
                bus.ir_write  = mem_go;
            end
            S_DECODE: bus.alu_src_b = SRCB_IMM_SH2;
            S_MEMADR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                bus.mem_rd = 1'b1;
                bus.ior_d  = 1'b1;
            end
            S_MEMWB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                bus.mem_wr = 1'b1;
                bus.ior_d  = 1'b1;
            end
            S_RTEX: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = ALUOP_FUNCT;
            end
            S_RTWB: begin
                bus.reg_write = 1'b1;
                bus.reg_dst   = 1'b1;
            end
            S_BEQEX: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = ALUOP_SUB;
                bus.pc_src    = PCSRC_ALUOUT;
                bus.pc_en     = bus.zero;
            end
            S_JEX: begin
                bus.pc_src = PCSRC_JUMP;
                bus.pc_en  = 1'b1;
            end
`ifdef MC_ADDI_EN
            S_ADDIEX: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = SRCB_IMM;
            end
            S_ADDIWB: bus.reg_write = 1'b1;
`endif
            S_TRAP:   bus.illegal = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_multicycle_main_control.sv
// tb/tb_multicycle_main_control.sv - scoreboard bench for multicycle_main_control
module tb_multicycle_main_control;
    import multicycle_main_control_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    multicycle_main_control_if #(.OPW(6)) bus ();

    multicycle_main_control #(.OPW(6), .ILLEGAL_HOLD(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  op;
        logic        mr;
        logic        z;
        logic [3:0]  st;
        logic [16:0] outs;
    } exp_t;

    exp_t exp_q[$];

    // Expected output vector per state, written from the state table.
    function automatic logic [16:0] spec_out(input logic [3:0] st, input logic mr, input logic z);
        logic [1:0] aop, sb, ps;
        logic sa, pe, iod, mrd, mwr, irw, rw, rd, m2r, ill;
        aop = 2'b00; sb = 2'b00; ps = 2'b00;
        {sa, pe, iod, mrd, mwr, irw, rw, rd, m2r, ill} = '0;
        case (st)
            4'd0:  begin mrd = 1'b1; sb = 2'b01; pe = mr; irw = mr; end
            4'd1:  sb = 2'b11;
            4'd2:  begin sa = 1'b1; sb = 2'b10; end
            4'd3:  begin mrd = 1'b1; iod = 1'b1; end
            4'd4:  begin rw = 1'b1; m2r = 1'b1; end
            4'd5:  begin mwr = 1'b1; iod = 1'b1; end
            4'd6:  begin sa = 1'b1; aop = 2'b10; end
            4'd7:  begin rw = 1'b1; rd = 1'b1; end
            4'd8:  begin sa = 1'b1; aop = 2'b01; ps = 2'b01; pe = z; end
            4'd9:  begin ps = 2'b10; pe = 1'b1; end
            4'd10: begin sa = 1'b1; sb = 2'b10; end
            4'd11: rw = 1'b1;
            4'd15: ill = 1'b1;
            default: ;
        endcase
        return {aop, sa, sb, ps, pe, iod, mrd, mwr, irw, rw, rd, m2r, ill};
    endfunction

    function automatic logic [16:0] observe();
        return {bus.alu_op, bus.alu_src_a, bus.alu_src_b, bus.pc_src, bus.pc_en, bus.ior_d,
                bus.mem_rd, bus.mem_wr, bus.ir_write, bus.reg_write, bus.reg_dst,
                bus.mem_to_reg, bus.illegal};
    endfunction

    function automatic void push(input logic [5:0] op, input logic mr, input logic z, input logic [3:0] st);
        exp_t e;
        e.op = op; e.mr = mr; e.z = z; e.st = st;
        e.outs = spec_out(st, mr, z);
        exp_q.push_back(e);
    endfunction

    task automatic test_reset();
        bus.opcode = 6'd0; bus.zero = 1'b0; bus.mem_ready = 1'b1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.state_dbg, observe()} !== {4'd0, spec_out(4'd0, 1'b0, 1'b0)}) begin
            errors++;
            $display("FAIL reset_hold: state=%0d outs=%05h expected state=0 outs=%05h",
                     bus.state_dbg, observe(), spec_out(4'd0, 1'b0, 1'b0));
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.state_dbg, observe()} !== {4'd0, spec_out(4'd0, 1'b1, 1'b0)}) begin
            errors++;
            $display("FAIL reset_first_fetch: state=%0d outs=%05h expected state=0 outs=%05h",
                     bus.state_dbg, observe(), spec_out(4'd0, 1'b1, 1'b0));
        end
        bus.mem_ready = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_rtype();
        exp_t e;
        push(OP_RTYPE, 1'b1, 1'b0, 4'd0);
        push(OP_RTYPE, 1'b1, 1'b0, 4'd1);
        push(OP_RTYPE, 1'b1, 1'b0, 4'd6);
        push(OP_RTYPE, 1'b1, 1'b0, 4'd7);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            bus.opcode = e.op; bus.mem_ready = e.mr; bus.zero = e.z;
            @(negedge clk);
            checks++;
            if ({bus.state_dbg, observe()} !== {e.st, e.outs}) begin
                errors++;
                $display("FAIL rtype: state=%0d outs=%05h expected state=%0d outs=%05h",
                         bus.state_dbg, observe(), e.st, e.outs);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_mem();
        exp_t e;
        // lw with a 2-cycle memory stall; pin switches to sw after DECODE
        push(OP_LW, 1'b1, 1'b0, 4'd0);
        push(OP_LW, 1'b1, 1'b0, 4'd1);
        push(OP_SW, 1'b1, 1'b0, 4'd2);
        push(OP_SW, 1'b0, 1'b0, 4'd3);
        push(OP_SW, 1'b0, 1'b0, 4'd3);
        push(OP_SW, 1'b1, 1'b0, 4'd3);
        push(OP_SW, 1'b1, 1'b0, 4'd4);
        // sw with a fetch stall and a store stall; pin switches to lw after DECODE
        push(OP_SW, 1'b0, 1'b0, 4'd0);
        push(OP_SW, 1'b1, 1'b0, 4'd0);
        push(OP_SW, 1'b1, 1'b0, 4'd1);
        push(OP_LW, 1'b1, 1'b0, 4'd2);
        push(OP_LW, 1'b0, 1'b0, 4'd5);
        push(OP_LW, 1'b1, 1'b0, 4'd5);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            bus.opcode = e.op; bus.mem_ready = e.mr; bus.zero = e.z;
            @(negedge clk);
            checks++;
            if ({bus.state_dbg, observe()} !== {e.st, e.outs}) begin
                errors++;
                $display("FAIL mem: op=%b state=%0d outs=%05h expected state=%0d outs=%05h",
                         e.op, bus.state_dbg, observe(), e.st, e.outs);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        push(OP_BEQ, 1'b1, 1'b1, 4'd0);
        push(OP_BEQ, 1'b1, 1'b1, 4'd1);
        push(OP_BEQ, 1'b1, 1'b1, 4'd8);
        push(OP_BEQ, 1'b1, 1'b0, 4'd0);
        push(OP_BEQ, 1'b1, 1'b0, 4'd1);
        push(OP_BEQ, 1'b1, 1'b0, 4'd8);
        push(OP_J,   1'b1, 1'b0, 4'd0);
        push(OP_J,   1'b1, 1'b0, 4'd1);
        push(OP_J,   1'b1, 1'b0, 4'd9);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            bus.opcode = e.op; bus.mem_ready = e.mr; bus.zero = e.z;
            @(negedge clk);
            checks++;
            if ({bus.state_dbg, observe()} !== {e.st, e.outs}) begin
                errors++;
                $display("FAIL branch_jump: op=%b z=%b state=%0d outs=%05h expected state=%0d outs=%05h",
                         e.op, e.z, bus.state_dbg, observe(), e.st, e.outs);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_addi();
        exp_t e;
        push(OP_ADDI, 1'b1, 1'b0, 4'd0);
        push(OP_ADDI, 1'b1, 1'b0, 4'd1);
`ifdef MC_ADDI_EN
        push(OP_ADDI, 1'b1, 1'b0, 4'd10);
        push(OP_ADDI, 1'b1, 1'b0, 4'd11);
`else
        push(OP_ADDI, 1'b1, 1'b0, 4'd15);
        push(OP_ADDI, 1'b1, 1'b0, 4'd15);
`endif
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            bus.opcode = e.op; bus.mem_ready = e.mr; bus.zero = e.z;
            @(negedge clk);
            checks++;
            if ({bus.state_dbg, observe()} !== {e.st, e.outs}) begin
                errors++;
                $display("FAIL addi: state=%0d outs=%05h expected state=%0d outs=%05h",
                         bus.state_dbg, observe(), e.st, e.outs);
            end
            @(posedge clk); #1;
        end
`ifndef MC_ADDI_EN
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
`endif
    endtask

    task automatic test_illegal();
        exp_t e;
        push(6'b111111, 1'b1, 1'b0, 4'd0);
        push(6'b111111, 1'b1, 1'b0, 4'd1);
        for (int i = 0; i < 10; i++) push(6'b111111, 1'b1, 1'b0, 4'd15);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            bus.opcode = e.op; bus.mem_ready = e.mr; bus.zero = e.z;
            @(negedge clk);
            checks++;
            if ({bus.state_dbg, observe()} !== {e.st, e.outs}) begin
                errors++;
                $display("FAIL illegal: state=%0d outs=%05h expected state=%0d outs=%05h",
                         bus.state_dbg, observe(), e.st, e.outs);
            end
            @(posedge clk); #1;
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({bus.state_dbg, bus.illegal} !== {4'd0, 1'b0}) begin
            errors++;
            $display("FAIL trap_async_reset: state=%0d illegal=%b expected state=0 illegal=0",
                     bus.state_dbg, bus.illegal);
        end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_reset_mid_access();
        exp_t e;
        push(OP_SW, 1'b1, 1'b0, 4'd0);
        push(OP_SW, 1'b1, 1'b0, 4'd1);
        push(OP_SW, 1'b1, 1'b0, 4'd2);
        push(OP_SW, 1'b0, 1'b0, 4'd5);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            bus.opcode = e.op; bus.mem_ready = e.mr; bus.zero = e.z;
            @(negedge clk);
            checks++;
            if ({bus.state_dbg, observe()} !== {e.st, e.outs}) begin
                errors++;
                $display("FAIL store_abort_setup: state=%0d outs=%05h expected state=%0d outs=%05h",
                         bus.state_dbg, observe(), e.st, e.outs);
            end
            @(posedge clk); #1;
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({bus.state_dbg, bus.mem_wr} !== {4'd0, 1'b0}) begin
            errors++;
            $display("FAIL store_abort: state=%0d mem_wr=%b expected state=0 mem_wr=0",
                     bus.state_dbg, bus.mem_wr);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        push(OP_RTYPE, 1'b1, 1'b0, 4'd0);
        push(OP_RTYPE, 1'b1, 1'b0, 4'd1);
        push(OP_RTYPE, 1'b1, 1'b0, 4'd6);
        push(OP_RTYPE, 1'b1, 1'b0, 4'd7);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            bus.opcode = e.op; bus.mem_ready = e.mr; bus.zero = e.z;
            @(negedge clk);
            checks++;
            if ({bus.state_dbg, observe()} !== {e.st, e.outs}) begin
                errors++;
                $display("FAIL after_abort: state=%0d outs=%05h expected state=%0d outs=%05h",
                         bus.state_dbg, observe(), e.st, e.outs);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        reset = 1'b1;
        test_reset();
        test_rtype();
        test_mem();
        test_back_to_back();
        test_addi();
        test_illegal();
        test_reset_mid_access();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
